// File: rtl/dmac_arb_pkg.sv
// Shared types and helpers for the DMAC system-bus arbiter.
package dmac_arb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_ID_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

  // Caller zero-extends the grant vector to 8 bits (N_REQ is at most 8).
  function automatic logic [2:0] onehot_to_id(input logic [7:0] oh);
    logic [2:0] id;
    id = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) id = 3'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/dmac_rr_pick.sv
// Combinational round-robin pick: first requester above `last`, wrapping.
module dmac_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  last_i,
  output logic [N_REQ-1:0] win_o,
  output logic             valid_o
);

  always_comb begin
    int idx;
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_i) + off) % N_REQ;
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmac_bus_arbiter.sv
// Round-robin, non-preemptive owner of the DMAC bus master port with
// registered one-hot grant, encoded id, busy flag and handoff pulse.
module dmac_bus_arbiter
  import dmac_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             bus_busy,
  output logic             handoff
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic             handoff_q, handoff_d;

  logic [N_REQ-1:0] win;
  logic             win_vld;
  logic [ID_W-1:0]  win_id;

  dmac_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i   (req),
    .last_i  (last_q),
    .win_o   (win),
    .valid_o (win_vld)
  );

  assign win_id = ID_W'(onehot_to_id(8'(win)));

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    handoff_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d    = ST_OWNED;
          grant_d    = win;
          grant_id_d = win_id;
          last_d     = win_id;
          handoff_d  = 1'b1;
        end else begin
          grant_d    = '0;
          grant_id_d = '0;
        end
      end
      ST_OWNED: begin
        // Owner's released bit is already 0, so the pick skips it naturally.
        if ((req & grant_q) == '0) begin
          if (win_vld) begin
            grant_d    = win;
            grant_id_d = win_id;
            last_d     = win_id;
            handoff_d  = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        grant_d    = '0;
        grant_id_d = '0;
      end
    endcase

    busy_d = |grant_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= ID_W'(N_REQ - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      handoff_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      handoff_q  <= handoff_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign bus_busy = busy_q;
  assign handoff  = handoff_q;

endmodule

// File: tb/tb_dmac_bus_arbiter.sv
// Bench for dmac_bus_arbiter: directed scenarios plus random traffic
// compared every cycle against an owner/last-pointer reference model.
module tb_dmac_bus_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [W-1:0] grant_id;
  logic         bus_busy;
  logic         handoff;

  int tests = 0;
  int fails = 0;

  dmac_bus_arbiter #(.N_REQ(N), .ID_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .bus_busy (bus_busy),
    .handoff  (handoff)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus and who was served last.
  int           m_owner = -1;
  int           m_last  = N - 1;
  logic         m_hs    = 1'b0;
  logic         m_valid = 1'b0;
  logic [N-1:0] m_grant;
  logic [W-1:0] m_id;
  logic         m_busy;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = -1;
      m_last  = N - 1;
      m_hs    = 1'b0;
      m_valid = 1'b1;
    end else if (m_owner >= 0 && req[m_owner]) begin
      m_hs = 1'b0;
    end else begin
      int w;
      w = -1;
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
      end
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_hs    = 1'b1;
      end else begin
        m_owner = -1;
        m_hs    = 1'b0;
      end
    end
    m_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    m_id    = (m_owner >= 0) ? W'(m_owner) : '0;
    m_busy  = (m_owner >= 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (grant !== m_grant || grant_id !== m_id || bus_busy !== m_busy ||
          handoff !== m_hs) begin
        fails++;
        $display("FAIL model t=%0t: grant=%b id=%0d busy=%b hs=%b, expected grant=%b id=%0d busy=%b hs=%b",
                 $time, grant, grant_id, bus_busy, handoff, m_grant, m_id, m_busy, m_hs);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [N-1:0] g_exp,
                     input logic [W-1:0] id_exp, input logic busy_exp,
                     input logic hs_exp);
    tests++;
    if (grant !== g_exp || grant_id !== id_exp || bus_busy !== busy_exp ||
        handoff !== hs_exp) begin
      fails++;
      $display("FAIL %s: grant=%b id=%0d busy=%b hs=%b, expected grant=%b id=%0d busy=%b hs=%b",
               name, grant, grant_id, bus_busy, handoff, g_exp, id_exp, busy_exp, hs_exp);
    end
  endtask

  initial begin
    int cur;
    int nxt;

    // Reset held with all requesting.
    @(negedge clk);
    reset = 1'b1;
    req   = 4'b1111;
    step();
    step();
    chk("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk("first_grant", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Rotation: each owner holds 3 cycles, drops for one.
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rot_hold", N'(1 << cur), W'(cur), 1'b1, 1'b0);
      step();
      req = 4'b1111 & ~N'(1 << cur);
      step();
      nxt = (cur + 1) % N;
      chk("rot_next", N'(1 << nxt), W'(nxt), 1'b1, 1'b1);
      req = 4'b1111;
      cur = nxt;
    end

    // Wrap and skip: owner 2, then 0011 pending -> requester 0.
    req = 4'b0100;
    step();
    chk("to_owner2", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0011;
    step();
    chk("wrap_skip", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Hold owner 1 for 20 cycles with requester 3 waiting.
    req = 4'b0010;
    step();
    chk("to_owner1", 4'b0010, 2'd1, 1'b1, 1'b1);
    req = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("hold", 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    req = 4'b1000;
    step();
    chk("after_hold", 4'b1000, 2'd3, 1'b1, 1'b1);

    // Idle return and re-request.
    req = 4'b0100;
    step();
    chk("to_owner2b", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b0000;
    step();
    chk("idle_return", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b0100;
    step();
    chk("regrant", 4'b0100, 2'd2, 1'b1, 1'b1);

    // Reset mid-transfer restores requester 0 priority.
    reset = 1'b1;
    req   = 4'b0101;
    step();
    chk("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk("post_reset", 4'b0001, 2'd0, 1'b1, 1'b1);

    // Random traffic: each bit flips with probability 1/4, rare resets.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] flip;
      flip = '0;
      for (int b = 0; b < N; b++) flip[b] = ($urandom_range(3) == 0);
      req   = req ^ flip;
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0;
    req   = '0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
